// File: rtl/redirect_ctrl.sv
// Branch redirect sequencer: detects EX mispredicts, flushes, drains wrong-path
// fetch responses, then hands the corrected PC to IF over valid/ready.
module redirect_ctrl #(
    parameter int unsigned OUTSTANDING_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [63:0] ex_pc,
    input  logic        ex_taken,
    input  logic [63:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [63:0] ex_pred_target,
    input  logic        if_req_fire,
    input  logic        if_resp_fire,
    output logic        flush,
    output logic        fetch_block,
    output logic        outstanding_full,
    output logic        drop_resp,
    output logic        redir_valid,
    output logic [63:0] redir_pc,
    input  logic        redir_ready,
    output logic [31:0] mispred_cnt
);

    localparam int unsigned CW    = $clog2(OUTSTANDING_MAX + 1);
    localparam int unsigned PCW   = 64;
    localparam int unsigned MCW   = 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;

    logic [1:0]     state, state_nxt;
    logic [CW-1:0]  out_cnt, out_cnt_nxt;
    logic [CW-1:0]  stale, stale_nxt;
    logic [PCW-1:0] redir_pc_nxt, correct_pc;
    logic [MCW-1:0] mispred_cnt_nxt;
    logic           flush_nxt;
    logic           req_ok, resp_ok, mispredict;

    // In-flight tracking; illegal requests at full / responses at empty are ignored
    always_comb begin
        req_ok      = if_req_fire && (out_cnt != CW'(OUTSTANDING_MAX));
        resp_ok     = if_resp_fire && (out_cnt != '0);
        out_cnt_nxt = out_cnt;
        if (req_ok && !resp_ok) begin
            out_cnt_nxt = out_cnt + CW'(1);
        end else if (!req_ok && resp_ok) begin
            out_cnt_nxt = out_cnt - CW'(1);
        end
    end

    assign correct_pc = ex_taken ? ex_target : (ex_pc + PCW'(4));
    assign mispredict = ex_valid && (state == S_IDLE) &&
                        ((ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target != ex_pred_target)));

    // Wrong-path responses are only those arriving while draining
    assign drop_resp = if_resp_fire && (state == S_DRAIN);

    // Next-state and registered-output logic
    always_comb begin
        state_nxt       = state;
        stale_nxt       = stale;
        redir_pc_nxt    = redir_pc;
        flush_nxt       = 1'b0;
        mispred_cnt_nxt = mispred_cnt;
        case (state)
            S_IDLE: begin
                if (mispredict) begin
                    flush_nxt    = 1'b1;
                    redir_pc_nxt = correct_pc;
                    stale_nxt    = out_cnt_nxt;
                    state_nxt    = (out_cnt_nxt != '0) ? S_DRAIN : S_SEND;
                    if (mispred_cnt != '1) begin
                        mispred_cnt_nxt = mispred_cnt + MCW'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (if_resp_fire && (stale != '0)) begin
                    stale_nxt = stale - CW'(1);
                    if (stale == CW'(1)) begin
                        state_nxt = S_SEND;
                    end
                end
            end
            S_SEND: begin
                if (redir_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_IDLE;
            out_cnt          <= '0;
            stale            <= '0;
            redir_pc         <= '0;
            flush            <= 1'b0;
            fetch_block      <= 1'b0;
            redir_valid      <= 1'b0;
            outstanding_full <= 1'b0;
            mispred_cnt      <= '0;
        end else begin
            state            <= state_nxt;
            out_cnt          <= out_cnt_nxt;
            stale            <= stale_nxt;
            redir_pc         <= redir_pc_nxt;
            flush            <= flush_nxt;
            fetch_block      <= (state_nxt != S_IDLE);
            redir_valid      <= (state_nxt == S_SEND);
            outstanding_full <= (out_cnt_nxt == CW'(OUTSTANDING_MAX));
            mispred_cnt      <= mispred_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_redirect_ctrl.sv
// Bench for redirect_ctrl: directed scenarios plus randomized traffic against
// a transaction-level model of pending redirects and in-flight fetches.
module tb_redirect_ctrl;

    localparam int unsigned MAX = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, ex_taken, ex_pred_taken;
    logic [63:0] ex_pc, ex_target, ex_pred_target;
    logic        if_req_fire, if_resp_fire, redir_ready;
    logic        flush, fetch_block, outstanding_full, drop_resp, redir_valid;
    logic [63:0] redir_pc;
    logic [31:0] mispred_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // model state
    int          m_cnt;
    bit          m_busy;
    int          m_drops;
    logic [63:0] m_pc;
    bit          m_flush;
    logic [31:0] m_mcnt;

    always #5 clk = ~clk;

    redirect_ctrl #(.OUTSTANDING_MAX(MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .if_req_fire(if_req_fire), .if_resp_fire(if_resp_fire),
        .flush(flush), .fetch_block(fetch_block), .outstanding_full(outstanding_full),
        .drop_resp(drop_resp), .redir_valid(redir_valid), .redir_pc(redir_pc),
        .redir_ready(redir_ready), .mispred_cnt(mispred_cnt)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        ex_valid = 0; ex_pc = '0; ex_taken = 0; ex_target = '0;
        ex_pred_taken = 0; ex_pred_target = '0;
        if_req_fire = 0; if_resp_fire = 0; redir_ready = 0;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_in();
        #1;
        n_checks++;
        if ({flush, fetch_block, drop_resp, redir_valid, outstanding_full} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000",
                     {flush, fetch_block, drop_resp, redir_valid, outstanding_full});
        else n_pass++;
        n_checks++;
        if (redir_pc !== 64'h0) $display("FAIL reset_pc: got %0h want 0", redir_pc);
        else n_pass++;
        n_checks++;
        if (mispred_cnt !== 32'h0) $display("FAIL reset_cnt: got %0d want 0", mispred_cnt);
        else n_pass++;
        cyc(); cyc();
        rst_n = 1;
        cyc();
    endtask

    task automatic test_correct_pred();
        ex_valid = 1; ex_taken = 0; ex_pred_taken = 0; ex_pc = 64'h8000_0000;
        ex_target = 64'h8000_0400; ex_pred_target = 64'h8000_0800;
        for (int i = 0; i < 3; i++) begin
            cyc();
            if (i == 0) ex_valid = 0;
            n_checks++;
            if ({flush, redir_valid, fetch_block} !== 3'b000)
                $display("FAIL correct_quiet: cyc %0d got %b want 000", i,
                         {flush, redir_valid, fetch_block});
            else n_pass++;
        end
        n_checks++;
        if (mispred_cnt !== 32'd0) $display("FAIL correct_cnt: got %0d want 0", mispred_cnt);
        else n_pass++;
    endtask

    task automatic test_taken_mispredict();
        ex_valid = 1; ex_pc = 64'h8000_0010; ex_taken = 1; ex_target = 64'h8000_0100;
        ex_pred_taken = 0; ex_pred_target = 64'h0; redir_ready = 1;
        cyc();
        ex_valid = 0;
        n_checks++;
        if ({flush, fetch_block, redir_valid} !== 3'b111)
            $display("FAIL taken_t1: got %b want 111", {flush, fetch_block, redir_valid});
        else n_pass++;
        n_checks++;
        if (redir_pc !== 64'h8000_0100) $display("FAIL taken_pc: got %0h want 80000100", redir_pc);
        else n_pass++;
        cyc();
        redir_ready = 0;
        n_checks++;
        if ({flush, fetch_block, redir_valid} !== 3'b000)
            $display("FAIL taken_t2: got %b want 000", {flush, fetch_block, redir_valid});
        else n_pass++;
        n_checks++;
        if (mispred_cnt !== 32'd1) $display("FAIL taken_cnt: got %0d want 1", mispred_cnt);
        else n_pass++;
    endtask

    task automatic test_stale_drain();
        int drops;
        drops = 0;
        if_req_fire = 1;
        cyc(); cyc();
        ex_valid = 1; ex_pc = 64'h8000_0020; ex_taken = 0; ex_pred_taken = 1;
        ex_target = 64'h8000_0900; ex_pred_target = 64'h8000_0900;
        cyc();
        if_req_fire = 0; ex_valid = 0;
        n_checks++;
        if ({flush, fetch_block, redir_valid} !== 3'b110)
            $display("FAIL stale_t1: got %b want 110", {flush, fetch_block, redir_valid});
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            if_resp_fire = 1;
            #1;
            if (drop_resp === 1'b1) drops++;
            n_checks++;
            if (drop_resp !== 1'b1) $display("FAIL stale_drop: resp %0d got %b want 1", i, drop_resp);
            else n_pass++;
            cyc();
            if_resp_fire = 0;
            n_checks++;
            if (redir_valid !== (i == 2))
                $display("FAIL stale_valid: after resp %0d got %b want %b", i, redir_valid, (i == 2));
            else n_pass++;
            if (i < 2) cyc();
        end
        n_checks++;
        if (redir_pc !== 64'h8000_0024) $display("FAIL stale_pc: got %0h want 80000024", redir_pc);
        else n_pass++;
        n_checks++;
        if (drops != 3) $display("FAIL stale_count: got %0d want 3", drops);
        else n_pass++;
        redir_ready = 1;
        cyc();
        redir_ready = 0;
        n_checks++;
        if ({fetch_block, redir_valid} !== 2'b00 || mispred_cnt !== 32'd2)
            $display("FAIL stale_done: got fb/rv %b cnt %0d want 00 cnt 2",
                     {fetch_block, redir_valid}, mispred_cnt);
        else n_pass++;
    endtask

    task automatic test_target_mismatch();
        ex_valid = 1; ex_pc = 64'h40; ex_taken = 1; ex_pred_taken = 1;
        ex_target = 64'h200; ex_pred_target = 64'h100; redir_ready = 1;
        cyc();
        ex_valid = 0;
        n_checks++;
        if ({flush, redir_valid} !== 2'b11 || redir_pc !== 64'h200)
            $display("FAIL target_t1: got fl/rv %b pc %0h want 11 pc 200", {flush, redir_valid}, redir_pc);
        else n_pass++;
        cyc();
        redir_ready = 0;
        n_checks++;
        if (fetch_block !== 1'b0 || mispred_cnt !== 32'd3)
            $display("FAIL target_done: got fb %b cnt %0d want 0 cnt 3", fetch_block, mispred_cnt);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        ex_valid = 1; ex_pc = 64'h1000; ex_taken = 1; ex_pred_taken = 0;
        ex_target = 64'h3000; ex_pred_target = 64'h0; redir_ready = 0;
        cyc();
        ex_valid = 0;
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (redir_valid !== 1'b1 || redir_pc !== 64'h3000)
                $display("FAIL bp_hold: cyc %0d got rv %b pc %0h want 1 pc 3000", k, redir_valid, redir_pc);
            else n_pass++;
            if (k == 2) begin
                n_checks++;
                if (flush !== 1'b0) $display("FAIL bp_noflush: got %b want 0", flush);
                else n_pass++;
            end
            ex_valid = (k == 1);
            ex_target = 64'h5000;
            if (k == 3) redir_ready = 1;
            cyc();
        end
        ex_valid = 0; redir_ready = 0;
        n_checks++;
        if ({redir_valid, fetch_block, flush} !== 3'b000 || mispred_cnt !== 32'd4)
            $display("FAIL bp_done: got rv/fb/fl %b cnt %0d want 000 cnt 4",
                     {redir_valid, fetch_block, flush}, mispred_cnt);
        else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        if_req_fire = 1;
        cyc(); cyc();
        if_req_fire = 0;
        ex_valid = 1; ex_pc = 64'h2000; ex_taken = 1; ex_pred_taken = 0;
        ex_target = 64'h7000; ex_pred_target = 64'h0;
        cyc();
        ex_valid = 0;
        n_checks++;
        if (fetch_block !== 1'b1 || redir_valid !== 1'b0)
            $display("FAIL rstd_drain: got fb %b rv %b want 1 0", fetch_block, redir_valid);
        else n_pass++;
        if_resp_fire = 1;
        rst_n = 0;
        #1;
        n_checks++;
        if ({flush, fetch_block, drop_resp, redir_valid, outstanding_full} !== 5'b0 ||
            redir_pc !== 64'h0 || mispred_cnt !== 32'h0)
            $display("FAIL rstd_async: got flags %b pc %0h cnt %0d want 0",
                     {flush, fetch_block, drop_resp, redir_valid, outstanding_full}, redir_pc, mispred_cnt);
        else n_pass++;
        if_resp_fire = 0;
        cyc();
        rst_n = 1;
        cyc();
        for (int i = 0; i < 4; i++) begin
            if_req_fire = 1;
            cyc();
            n_checks++;
            if (outstanding_full !== (i == 3))
                $display("FAIL rstd_full: after req %0d got %b want %b", i, outstanding_full, (i == 3));
            else n_pass++;
        end
        if_req_fire = 0;
        for (int i = 0; i < 4; i++) begin
            if_resp_fire = 1;
            #1;
            n_checks++;
            if (drop_resp !== 1'b0) $display("FAIL rstd_nodrop: resp %0d got %b want 0", i, drop_resp);
            else n_pass++;
            cyc();
        end
        if_resp_fire = 0;
    endtask

    // Applies one clock of the reference model using the inputs held during that cycle
    task automatic model_step();
        bit          mis;
        int          next_cnt;
        logic [63:0] good_pc;
        mis = ex_valid && !m_busy &&
              ((ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target));
        good_pc  = ex_taken ? ex_target : ex_pc + 64'd4;
        next_cnt = m_cnt + int'(if_req_fire) - int'(if_resp_fire);
        m_flush  = mis;
        if (mis) begin
            m_busy  = 1;
            m_drops = next_cnt;
            m_pc    = good_pc;
            if (m_mcnt != 32'hFFFF_FFFF) m_mcnt = m_mcnt + 32'd1;
        end else if (m_busy && m_drops > 0) begin
            if (if_resp_fire) m_drops--;
        end else if (m_busy && redir_ready) begin
            m_busy = 0;
        end
        m_cnt = next_cnt;
    endtask

    task automatic test_random();
        bit exp_drop;
        rst_n = 0;
        idle_in();
        cyc();
        rst_n = 1;
        m_cnt = 0; m_busy = 0; m_drops = 0; m_pc = '0; m_flush = 0; m_mcnt = '0;
        for (int n = 0; n < 600; n++) begin
            ex_valid      = ($urandom_range(0, 2) == 0);
            ex_pc         = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC
                                                         : {$urandom, $urandom} & ~64'h3;
            ex_taken      = 1'($urandom_range(0, 1));
            ex_pred_taken = ($urandom_range(0, 3) == 0) ? ~ex_taken : ex_taken;
            ex_target     = {$urandom, $urandom};
            ex_pred_target = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : ex_target;
            if_req_fire   = !m_busy && (m_cnt < MAX) && ($urandom_range(0, 1) == 1);
            if_resp_fire  = (m_cnt > 0) && ($urandom_range(0, 2) == 0);
            redir_ready   = 1'($urandom_range(0, 1));
            assert (!(if_req_fire && m_cnt == MAX)) else $error("request issued at full");
            assert (!(if_resp_fire && m_cnt == 0)) else $error("response with none in flight");
            exp_drop = if_resp_fire && m_busy && (m_drops > 0);
            #1;
            n_checks++;
            if (drop_resp !== exp_drop) $display("FAIL rnd_drop: cyc %0d got %b want %b", n, drop_resp, exp_drop);
            else n_pass++;
            @(posedge clk);
            model_step();
            #1;
            n_checks++;
            if (flush !== m_flush) $display("FAIL rnd_flush: cyc %0d got %b want %b", n, flush, m_flush);
            else n_pass++;
            n_checks++;
            if (fetch_block !== m_busy) $display("FAIL rnd_block: cyc %0d got %b want %b", n, fetch_block, m_busy);
            else n_pass++;
            n_checks++;
            if (redir_valid !== (m_busy && m_drops == 0))
                $display("FAIL rnd_valid: cyc %0d got %b want %b", n, redir_valid, (m_busy && m_drops == 0));
            else n_pass++;
            n_checks++;
            if (redir_pc !== m_pc) $display("FAIL rnd_pc: cyc %0d got %0h want %0h", n, redir_pc, m_pc);
            else n_pass++;
            n_checks++;
            if (outstanding_full !== (m_cnt == MAX))
                $display("FAIL rnd_full: cyc %0d got %b want %b", n, outstanding_full, (m_cnt == MAX));
            else n_pass++;
            n_checks++;
            if (mispred_cnt !== m_mcnt) $display("FAIL rnd_cnt: cyc %0d got %0d want %0d", n, mispred_cnt, m_mcnt);
            else n_pass++;
        end
        idle_in();
    endtask

    initial begin
        test_reset();
        test_correct_pred();
        test_taken_mispredict();
        test_stale_drain();
        test_target_mismatch();
        test_backpressure();
        test_reset_mid_drain();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/redirect_ctrl.md
# redirect_ctrl

Sequences control-flow redirects produced by the EX-stage branch unit. It compares each resolved branch or jump against the prediction it carried down the pipe. On a mispredict it pulses a pipeline flush and blocks new fetches. It then drains and discards fetch responses still in flight from the wrong path, and finally hands the corrected PC to the fetch stage over a valid/ready handshake. It sits between EX (branch resolution) and IF (PC select / instruction memory request logic).

## Interface
Parameters:
- OUTSTANDING_MAX, 4, maximum in-flight fetch requests; counters are $clog2(OUTSTANDING_MAX+1) bits wide.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- ex_valid  in  1  EX holds a valid control-flow instruction (branch-select nonzero)
- ex_pc  in  64  PC of that instruction
- ex_taken  in  1  resolved direction (redirect_valid of branch unit)
- ex_target  in  64  resolved taken target (br_out of branch unit)
- ex_pred_taken  in  1  direction predicted at fetch
- ex_pred_target  in  64  target predicted at fetch
- if_req_fire  in  1  fetch request accepted by memory this cycle
- if_resp_fire  in  1  fetch response returned this cycle
- flush  out  1  one-cycle pulse: kill all instructions younger than EX
- fetch_block  out  1  IF must not issue requests
- outstanding_full  out  1  in-flight count == OUTSTANDING_MAX
- drop_resp  out  1  current response is wrong-path; IF discards it
- redir_valid  out  1  corrected PC available
- redir_pc  out  64  corrected PC
- redir_ready  in  1  IF accepts redir_pc
- mispred_cnt  out  32  saturating mispredict counter

## Operation
- Correct next PC: ex_taken ? ex_target : ex_pc + 4 (64-bit, wraps modulo 2^64).
- Mispredict: ex_valid && state==IDLE && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
- ex_valid outside IDLE is ignored; such an instruction is already wrong-path.
- In-flight counter `out_cnt`: +1 on if_req_fire, -1 on if_resp_fire; both in one cycle gives no change.
- Requests at full and responses at zero are protocol violations; the bench asserts on them, and the RTL leaves `out_cnt` unchanged.
- Stale count at detection: `stale = out_cnt + if_req_fire - if_resp_fire`.
- States and transitions:
  - IDLE: on mispredict, latch redir_pc and the stale count, raise flush for the next cycle, go to DRAIN if stale > 0, else SEND.
  - DRAIN: each if_resp_fire decrements stale. When the last stale response fires, go to SEND.
  - SEND: redir_valid=1, redir_pc stable. When redir_valid && redir_ready, go to IDLE.
- drop_resp = if_resp_fire && state==DRAIN (combinational).
- fetch_block = state != IDLE (registered with state).
- mispred_cnt increments on each mispredict and saturates at 0xFFFF_FFFF.

## Timing
- Reset values: state IDLE, flush 0, fetch_block 0, drop_resp 0, redir_valid 0, redir_pc 0, out_cnt 0, mispred_cnt 0, outstanding_full 0.
- Mispredict detected combinationally in cycle T. flush=1 in T+1 only, and fetch_block=1 from T+1.
- With stale=0: redir_valid=1 from T+1. If redir_ready=1 in T+1, the handshake completes and redir_valid=0, fetch_block=0 in T+2. Minimum redirect latency is 1 cycle and the block is busy for 1 cycle.
- With stale=N: redir_valid rises the cycle after the Nth dropped response.
- redir_valid, once high, holds with redir_pc unchanged until accepted.
- A new mispredict is accepted in the same cycle the SEND handshake completes only if state is already IDLE, i.e. the following cycle.
- Asynchronous reset mid-DRAIN or mid-SEND returns all outputs to reset values immediately and discards the latched redirect.

## Test plan
- Correct prediction: ex_valid=1, ex_taken=0, pred_taken=0, ex_pc=0x8000_0000 -> flush never asserts, redir_valid stays 0, mispred_cnt stays 0.
- Taken mispredict, out_cnt=0: ex_pc=0x8000_0010, ex_taken=1, ex_target=0x8000_0100, pred_taken=0, redir_ready=1 -> flush in T+1, redir_valid with redir_pc=0x8000_0100 in T+1, fetch_block=0 in T+2, mispred_cnt=1.
- Not-taken mispredict with 2 in flight, plus req_fire in T: pred_taken=1, ex_taken=0, ex_pc=0x8000_0020 -> stale=3; exactly 3 responses carry drop_resp=1; redir_pc=0x8000_0024 is valid the cycle after the third response.
- Target mismatch on jump: ex_taken=1, pred_taken=1, pred_target=0x100, ex_target=0x200 -> mispredict; redir_pc=0x200.
- Backpressure: redir_ready=0 for 3 cycles after redir_valid rises -> redir_valid and redir_pc stable for 4 cycles, and a second ex_valid mispredict during that window is ignored.
- Reset mid-DRAIN: assert rst_n=0 with stale=2 -> all outputs return to reset values immediately; after release, out_cnt=0 and state IDLE.
